// File: rtl/fetch_bp.sv
// Instruction-fetch stage: PC register, direct-mapped BTB with 2-bit counters,
// and the IF/ID pipeline register. Supports stall, redirect and EX-stage training.
module fetch_bp #(
    parameter int          BTB_DEPTH       = 16,
    parameter int          INST_MEM_ADDR_W = 10,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_stall,
    input  logic                       i_redirect,
    input  logic [31:0]                i_redirect_pc,
    input  logic                       i_upd_vld,
    input  logic [31:0]                i_upd_pc,
    input  logic                       i_upd_taken,
    input  logic [31:0]                i_upd_target,
    output logic [INST_MEM_ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]                i_imem_inst,
    output logic                       o_if_vld,
    output logic [31:0]                o_if_pc,
    output logic [31:0]                o_if_inst,
    output logic                       o_if_pred_taken,
    output logic [31:0]                o_if_pred_target
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = 30 - IDX_W;

    logic             btb_vld [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag [BTB_DEPTH];
    logic [31:0]      btb_tgt [BTB_DEPTH];
    logic [1:0]       btb_ctr [BTB_DEPTH];

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic [31:0]      pred_pc;
    logic [31:0]      pc_nxt;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             pred_taken;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [3:0]       unused_lsbs;

    assign unused_lsbs = {i_redirect_pc[1:0], i_upd_pc[1:0]};

    assign o_imem_addr = pc[INST_MEM_ADDR_W-1:0];

    // Lookup reads the array as it stands before this edge's training write.
    assign lk_idx     = pc[IDX_W+1:2];
    assign lk_tag     = pc[31:IDX_W+2];
    assign lk_hit     = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign pred_taken = lk_hit && btb_ctr[lk_idx][1];
    assign pc_plus4   = pc + 32'd4;
    assign pred_pc    = pred_taken ? btb_tgt[lk_idx] : pc_plus4;

    assign up_idx = i_upd_pc[IDX_W+1:2];
    assign up_tag = i_upd_pc[31:IDX_W+2];
    assign up_hit = btb_vld[up_idx] && (btb_tag[up_idx] == up_tag);

    always_comb begin
        pc_nxt = pred_pc;
        if (i_redirect)
            pc_nxt = {i_redirect_pc[31:2], 2'b00};
        else if (i_stall)
            pc_nxt = pc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc               <= RESET_PC;
            o_if_vld         <= 1'b0;
            o_if_pc          <= 32'h0;
            o_if_inst        <= 32'h0;
            o_if_pred_taken  <= 1'b0;
            o_if_pred_target <= 32'h0;
        end else begin
            pc <= pc_nxt;
            if (i_redirect) begin
                o_if_vld <= 1'b0;
            end else if (!i_stall) begin
                o_if_vld         <= 1'b1;
                o_if_pc          <= pc;
                o_if_inst        <= i_imem_inst;
                o_if_pred_taken  <= pred_taken;
                o_if_pred_target <= pred_pc;
            end
        end
    end

    // Training is independent of stall/redirect; only reset blocks it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_vld[i] <= 1'b0;
                btb_ctr[i] <= 2'b01;
            end
        end else if (i_upd_vld) begin
            if (up_hit) begin
                if (i_upd_taken) begin
                    if (btb_ctr[up_idx] != 2'b11)
                        btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'b01;
                end else if (btb_ctr[up_idx] != 2'b00) begin
                    btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'b01;
                end
            end else if (i_upd_taken) begin
                btb_vld[up_idx] <= 1'b1;
                btb_ctr[up_idx] <= 2'b10;
            end
        end
    end

    // A taken update either refreshes a hit's target or allocates; tag is rewritten either way.
    always_ff @(posedge i_clk) begin
        if (i_upd_vld && i_upd_taken) begin
            btb_tag[up_idx] <= up_tag;
            btb_tgt[up_idx] <= i_upd_target;
        end
    end
endmodule

// File: tb/tb_fetch_bp.sv
// Bench for fetch_bp: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of PC, IF/ID and the BTB.
module tb_fetch_bp;
    localparam int DEPTH = 16;
    localparam int AW    = 10;

    logic          i_clk = 1'b0;
    logic          i_rst, i_stall, i_redirect, i_upd_vld, i_upd_taken;
    logic [31:0]   i_redirect_pc, i_upd_pc, i_upd_target, i_imem_inst;
    logic [AW-1:0] o_imem_addr;
    logic          o_if_vld, o_if_pred_taken;
    logic [31:0]   o_if_pc, o_if_inst, o_if_pred_target;

    always #5 i_clk = ~i_clk;

    assign i_imem_inst = 32'hC0DE_0000 | 32'(o_imem_addr);

    fetch_bp #(.BTB_DEPTH(DEPTH), .INST_MEM_ADDR_W(AW), .RESET_PC(32'h0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .i_upd_vld(i_upd_vld), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
        .i_upd_target(i_upd_target), .o_imem_addr(o_imem_addr), .i_imem_inst(i_imem_inst),
        .o_if_vld(o_if_vld), .o_if_pc(o_if_pc), .o_if_inst(o_if_inst),
        .o_if_pred_taken(o_if_pred_taken), .o_if_pred_target(o_if_pred_target)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc = 0, m_if_pc = 0, m_if_inst = 0, m_if_tgt = 0;
    logic        m_if_vld = 0, m_if_pt = 0;
    bit          m_vld [DEPTH];
    logic [31:0] m_tag [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    int          m_ctr [DEPTH];

    task automatic cycle(bit rst, bit stall, bit redir, logic [31:0] rpc,
                         bit uv, logic [31:0] upc, bit ut, logic [31:0] utgt);
        int          li, ui;
        logic [31:0] lt, utag, ppc;
        bit          hit, pt;
        i_rst = rst; i_stall = stall; i_redirect = redir; i_redirect_pc = rpc;
        i_upd_vld = uv; i_upd_pc = upc; i_upd_taken = ut; i_upd_target = utgt;

        li  = int'((m_pc / 4) % DEPTH);
        lt  = m_pc / (4 * DEPTH);
        hit = m_vld[li] && (m_tag[li] == lt);
        pt  = hit && (m_ctr[li] >= 2);
        ppc = pt ? m_tgt[li] : m_pc + 32'd4;

        if (rst) begin
            m_pc = 0; m_if_vld = 0; m_if_pc = 0; m_if_inst = 0; m_if_pt = 0; m_if_tgt = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_vld[i] = 0;
                m_ctr[i] = 1;
            end
        end else begin
            if (redir) begin
                m_if_vld = 0;
                m_pc     = rpc & ~32'h3;
            end else if (!stall) begin
                m_if_vld  = 1;
                m_if_pc   = m_pc;
                m_if_inst = 32'hC0DE_0000 | (m_pc & 32'h3FF);
                m_if_pt   = pt;
                m_if_tgt  = ppc;
                m_pc      = ppc;
            end
            if (uv) begin
                ui   = int'((upc / 4) % DEPTH);
                utag = upc / (4 * DEPTH);
                if (m_vld[ui] && m_tag[ui] == utag) begin
                    if (ut) begin
                        m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                        m_tgt[ui] = utgt;
                    end else begin
                        m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                    end
                end else if (ut) begin
                    m_vld[ui] = 1; m_tag[ui] = utag; m_tgt[ui] = utgt; m_ctr[ui] = 2;
                end
            end
        end

        @(posedge i_clk);
        @(negedge i_clk);
        check("imem_addr", 32'(o_imem_addr), m_pc & 32'h3FF);
        check("if_vld", 32'(o_if_vld), 32'(m_if_vld));
        check("if_pc", o_if_pc, m_if_pc);
        check("if_inst", o_if_inst, m_if_inst);
        check("if_pred_taken", 32'(o_if_pred_taken), 32'(m_if_pt));
        check("if_pred_target", o_if_pred_target, m_if_tgt);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(logic [31:0] t);
        cycle(0, 0, 1, t, 0, 0, 0, 0);
    endtask

    task automatic train(logic [31:0] p, bit taken, logic [31:0] t);
        cycle(0, 0, 0, 0, 1, p, taken, t);
    endtask

    initial begin
        logic [31:0] rpc, upc;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_vld", 32'(o_if_vld), 32'h0);
        check("reset_addr", 32'(o_imem_addr), 32'h0);

        idle();
        check("seq_first_pc", o_if_pc, 32'h0);
        check("seq_first_vld", 32'(o_if_vld), 32'h1);
        idle();
        check("seq_second_pc", o_if_pc, 32'h4);
        repeat (3) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("stall_if_pc", o_if_pc, 32'h4);
        check("stall_pc", 32'(o_imem_addr), 32'h8);
        cycle(0, 1, 1, 32'h103, 0, 0, 0, 0);
        check("redir_flush", 32'(o_if_vld), 32'h0);
        idle();
        check("redir_target_pc", o_if_pc, 32'h100);

        train(32'h40, 1, 32'h200);
        redirect(32'h40);
        idle();
        check("alloc_pred_taken", 32'(o_if_pred_taken), 32'h1);
        check("alloc_pred_target", o_if_pred_target, 32'h200);
        idle();
        check("alloc_follow_pc", o_if_pc, 32'h200);

        train(32'h40, 1, 32'h200);
        train(32'h40, 0, 0);
        redirect(32'h40);
        idle();
        check("hyst_one_nt", 32'(o_if_pred_taken), 32'h1);
        train(32'h40, 0, 0);
        redirect(32'h40);
        idle();
        check("hyst_two_nt", 32'(o_if_pred_taken), 32'h0);
        check("hyst_two_nt_tgt", o_if_pred_target, 32'h44);
        train(32'h40, 0, 0);
        train(32'h40, 0, 0);
        train(32'h40, 1, 32'h200);
        redirect(32'h40);
        idle();
        check("hyst_saturate_low", 32'(o_if_pred_taken), 32'h0);

        train(32'h40, 1, 32'h200);
        train(32'h80, 1, 32'h300);
        redirect(32'h40);
        idle();
        check("alias_evicted", 32'(o_if_pred_taken), 32'h0);
        check("alias_evicted_tgt", o_if_pred_target, 32'h44);
        redirect(32'h80);
        idle();
        check("alias_new_tgt", o_if_pred_target, 32'h300);

        redirect(32'hC0);
        train(32'hC0, 1, 32'h400);
        check("same_cycle_old", 32'(o_if_pred_taken), 32'h0);
        check("same_cycle_old_tgt", o_if_pred_target, 32'hC4);
        redirect(32'hC0);
        idle();
        check("same_cycle_new_tgt", o_if_pred_target, 32'h400);

        redirect(32'hFFFF_FFFC);
        idle();
        check("wrap_if_pc", o_if_pc, 32'hFFFF_FFFC);
        check("wrap_pred_target", o_if_pred_target, 32'h0);
        idle();
        check("wrap_next_pc", o_if_pc, 32'h0);

        cycle(1, 1, 1, 32'h100, 1, 32'h40, 1, 32'h200);
        check("midreset_vld", 32'(o_if_vld), 32'h0);
        check("midreset_addr", 32'(o_imem_addr), 32'h0);
        idle();
        check("midreset_first_pc", o_if_pc, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 1023));
            upc = 32'($urandom_range(0, 1023)) & ~32'h3;
            if ($urandom_range(0, 7) == 0) upc = upc | 32'h400;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, rpc,
                  $urandom_range(0, 1) == 1, upc, $urandom_range(0, 2) != 0,
                  32'($urandom_range(0, 1023)) & ~32'h3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_bp.md
# fetch_bp

Instruction-fetch stage with a branch target buffer (BTB) for the pipelined RV32I core. It replaces the flat `pc <= pc_sel ? alu_res : pc+4` fetch of the single-cycle datapath. The block holds the PC and drives the asynchronous-read instruction memory. It predicts taken control transfers with a direct-mapped BTB of 2-bit saturating counters and registers the fetched instruction into the IF/ID pipeline register. It also supports stall, flush/redirect and BTB training from the execute stage.

## Interface
- `BTB_DEPTH`, 16: number of BTB entries, a power of two, ≥2; `IDX_W = log2(BTB_DEPTH)`, `TAG_W = 30 - IDX_W`.
- `INST_MEM_ADDR_W`, 10: byte-address width of the instruction memory.
- `RESET_PC`, 32'h0: PC after reset; bits [1:0] are 0.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_stall` in 1: hold PC and IF/ID (hazard from decode).
- `i_redirect` in 1: mispredict or exception redirect from EX; overrides `i_stall`.
- `i_redirect_pc` in 32: redirect target.
- `i_upd_vld` in 1: a branch or jump resolved in EX this cycle.
- `i_upd_pc` in 32: PC of the resolved instruction.
- `i_upd_taken` in 1: resolved direction.
- `i_upd_target` in 32: resolved target.
- `o_imem_addr` out INST_MEM_ADDR_W: `pc[INST_MEM_ADDR_W-1:0]`, combinational.
- `i_imem_inst` in 32: instruction at `o_imem_addr`, same cycle.
- `o_if_vld` out 1: IF/ID entry holds a real instruction.
- `o_if_pc` out 32: PC of the IF/ID instruction.
- `o_if_inst` out 32: the IF/ID instruction.
- `o_if_pred_taken` out 1: the BTB predicted taken for this instruction.
- `o_if_pred_target` out 32: the predicted next PC (`pc+4` when not taken).

## Operation
- **BTB entry:** valid bit, tag `[TAG_W-1:0]`, target `[31:0]`, 2-bit counter.
- **BTB index and tag:** index = `pc[IDX_W+1:2]`, tag = `pc[31:IDX_W+2]`.
- **Lookup (combinational on current pc):** `hit` = valid & tag match; `pred_taken` = `hit & ctr[1]`; `pred_pc` = `pred_taken ? target : pc+4`.
- **Next-PC priority:**
  1. `i_rst` → `RESET_PC`
  2. `i_redirect` → `{i_redirect_pc[31:2],2'b00}`
  3. `i_stall` → `pc`
  4. otherwise → `pred_pc`
- **PC arithmetic:** `pc+4` is modulo 2^32, so `32'hFFFF_FFFC` wraps to 0.
- **IF/ID register, same priority order:**
  - reset: all fields cleared (`o_if_vld`=0).
  - redirect: `o_if_vld`=0 (flush); other fields don't-care but deterministic (hold).
  - stall: all fields hold.
  - otherwise: load `pc`, `i_imem_inst`, `pred_taken`, `pred_pc`, and set `o_if_vld`=1.
- **BTB update (when `i_upd_vld`), indexed and tagged by `i_upd_pc`:**
  - Hit, taken: counter increments, saturating at 2'b11; target ← `i_upd_target`.
  - Hit, not taken: counter decrements, saturating at 2'b00; entry stays valid.
  - Miss, taken: allocate (overwrite) the entry: valid=1, new tag, target, counter=2'b10.
  - Miss, not taken: no change.
- **Stall and training:** BTB training proceeds regardless of `i_stall` and `i_redirect`.
- **Reset effect on BTB:** all valid bits clear and counters go to 2'b01. Targets and tags need not be reset.

## Timing
- Fetch-to-IF/ID latency is 1 cycle. The instruction presented at edge N appears on `o_if_*` after edge N.
- **Redirect asserted in cycle N:**
  - After edge N: `pc` = target and `o_if_vld`=0.
  - After edge N+1: the target instruction is valid in IF/ID, unless stalled.
  - Penalty: 1 bubble.
- **Update/lookup ordering:** an update to the index being looked up in the same cycle is not bypassed. The lookup sees the pre-update contents, and the write lands at the edge.
- **Stall:** stall held for k cycles keeps `pc` and `o_if_*` constant for k edges. Deasserting it resumes on the next edge.
- **Simultaneous stall and redirect:** redirect wins.
- **Reset:** reset asserted mid-stream takes effect at the next edge regardless of other inputs. First valid output is 1 cycle after reset release, with `o_if_pc`=`RESET_PC`.

## Test plan
- **Reset and sequential fetch:** reset, release, imem returns `addr` as data → `o_if_pc` = 0, 4, 8…, `o_if_inst` tracks, `o_if_vld`=1 from the second edge, `o_if_pred_taken`=0.
- **Stall, then redirect during stall:**
  - Stall 3 cycles at pc=8 → `o_if_pc` holds 4 and `pc` holds 8.
  - Redirect to 32'h103 during the stall → next `o_if_vld`=0, then `o_if_pc`=32'h100.
- **Allocation and prediction:**
  - Update pc=32'h40, taken, target=32'h200 → entry allocated with counter 10.
  - Next fetch of 32'h40 → `o_if_pred_taken`=1, `o_if_pred_target`=32'h200, and the following `o_if_pc`=32'h200.
- **Hysteresis:**
  - From counter 11, one not-taken update → still predicts taken.
  - A second not-taken update → predicts not taken (target 32'h44).
  - Further not-taken updates saturate at 00.
- **Aliasing:** with DEPTH=16, allocate 32'h40, then taken-update 32'h80 (same index, different tag) → 32'h40 now misses and predicts 32'h44.
- **Same-cycle update and wrap:**
  - Update the index of the current pc in the same cycle → the prediction uses old contents; the new entry is used on the next fetch.
  - Redirect to 32'hFFFF_FFFC → the following pc is 0.
